// File: rtl/sdram_arb_pkg.sv
// Shared constants for the sdram host-port arbiter: FSM encoding, operation codes, default widths.
package sdram_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: grants the lowest requesting index at or above ptr,
// wrapping to the lowest requesting index overall when nothing at or above ptr is requesting.
module sdram_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    // A requester at or above the pointer overrides the wrapped choice.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) idx = IW'(i);
    end
    grant = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the sdram_controller host port among NREQ requesters, one transaction
// in flight. Defining SDRAM_ARB_WATCHDOG_EN adds an ISSUE/BUSY timeout that aborts with err.
module sdram_host_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int ISSUE_MAX = 8,
  parameter int BUSY_MAX  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic [AW-1:0]    c_wr_addr,
  output logic [DW-1:0]    c_wr_data,
  output logic             c_wr_enable,
  output logic             c_rd_enable,
  input  logic             c_busy,
  input  logic [DW-1:0]    c_rd_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            abort;

  sdram_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        // A high busy in IDLE means the controller is refreshing; hold off granting.
        if (!c_busy && pick_valid) begin
          state_d = ST_ISSUE;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
              we_d    = req_we[i];
              addr_d  = req_addr[i*AW +: AW];
              wdata_d = req_wdata[i*DW +: DW];
            end
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_DONE;
          rdata_d = '0;
        end else if (c_busy) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (abort) begin
          state_d = ST_DONE;
          rdata_d = '0;
        end else if (!c_busy) begin
          state_d = ST_DONE;
          rdata_d = (we_q == OP_RD) ? c_rd_data : '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = OP_RD;
        addr_d  = '0;
        wdata_d = '0;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Enables decode straight from the state flop so an async reset drops them at once.
  assign c_wr_enable = (state_q == ST_ISSUE) && (we_q == OP_WR);
  assign c_rd_enable = (state_q == ST_ISSUE) && (we_q == OP_RD);
  assign c_wr_addr   = addr_q;
  assign c_wr_data   = wdata_q;
  assign rdata       = rdata_q;
  assign ack         = (state_q == ST_DONE) ? (NREQ'(1) << owner_q) : '0;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(BUSY_MAX + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          aborted_q, aborted_d;

  assign abort = ((state_q == ST_ISSUE) && !c_busy && (wd_cnt_q == CW'(ISSUE_MAX - 1))) ||
                 ((state_q == ST_BUSY)  &&  c_busy && (wd_cnt_q == CW'(BUSY_MAX - 1)));

  // Counter restarts on every state entry, so it measures time spent in the current wait state.
  always_comb begin
    wd_cnt_d  = '0;
    if ((state_d == state_q) && ((state_q == ST_ISSUE) || (state_q == ST_BUSY)))
      wd_cnt_d = wd_cnt_q + 1'b1;
    aborted_d = abort | (aborted_q & (state_q != ST_DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign err = (state_q == ST_DONE) && aborted_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Bench for sdram_host_arbiter: behavioural controller model plus a transaction-level round-robin
// reference; the watchdog scenario is selected by SDRAM_ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_sdram_host_arbiter;

  localparam int NREQ      = 2;
  localparam int AW        = 24;
  localparam int DW        = 16;
  localparam int ISSUE_MAX = 8;
  localparam int BUSY_MAX  = 255;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               err;
  logic [AW-1:0]      c_wr_addr;
  logic [DW-1:0]      c_wr_data;
  logic               c_wr_enable;
  logic               c_rd_enable;
  logic               c_busy = 1'b0;
  logic [DW-1:0]      c_rd_data = '0;

  int checks = 0;
  int errors = 0;

  int            busy_len = 3;
  int            busy_cnt = 0;
  logic          refresh = 1'b0;
  logic          no_response = 1'b0;
  logic [DW-1:0] rd_value = '0;
  logic          ctl_en_s;
  logic          ctl_busy_s;
  logic [NREQ-1:0] req_edge = '0;

  logic          m_we   [NREQ];
  logic [AW-1:0] m_addr [NREQ];
  logic [DW-1:0] m_data [NREQ];

  sdram_host_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .ISSUE_MAX(ISSUE_MAX), .BUSY_MAX(BUSY_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .c_wr_enable(c_wr_enable), .c_rd_enable(c_rd_enable), .c_busy(c_busy), .c_rd_data(c_rd_data)
  );

  always #5 clk = ~clk;

  // Controller model: an enable seen at an edge while idle starts busy_len cycles of busy;
  // read data becomes valid as busy falls. refresh forces busy high independently.
  always @(posedge clk) begin
    ctl_en_s   = c_wr_enable | c_rd_enable;
    ctl_busy_s = c_busy;
    req_edge   = req;
    #1;
    if (rst) begin
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) c_rd_data = rd_value;
    end else if (ctl_en_s && !ctl_busy_s && !no_response) begin
      busy_cnt  = busy_len;
      c_rd_data = DW'($urandom);
    end
    c_busy = (busy_cnt > 0) || refresh;
  end

  // Reference arbitration: first requester found walking upward from the pointer, wrapping.
  function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    refresh = 1'b0; no_response = 1'b0; busy_len = 3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    m_we[i] = we; m_addr[i] = a; m_data[i] = d;
  endtask

  task automatic wait_en(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (c_wr_enable === 1'b1 || c_rd_enable === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ack !== '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    checks++;
    if (ack !== '0 || err !== 1'b0 || c_wr_enable !== 1'b0 || c_rd_enable !== 1'b0 ||
        c_wr_addr !== '0 || c_wr_data !== '0 || rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ack=%b err=%b wr_en=%b rd_en=%b addr=%h data=%h rdata=%h, expected all 0",
               ack, err, c_wr_enable, c_rd_enable, c_wr_addr, c_wr_data, rdata);
    end
    no_response = 1'b1;
    set_req(0, 1'b1, 24'h000ABC, 16'h1234);
    wait_en(10, ok);
    checks++;
    if (!ok || c_wr_enable !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_pre_issue: wr_en=%b, expected 1", c_wr_enable);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (c_wr_enable !== 1'b0 || c_rd_enable !== 1'b0 || ack !== '0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_txn: wr_en=%b rd_en=%b ack=%b err=%b, expected 0 0 00 0",
               c_wr_enable, c_rd_enable, ack, err);
    end
    @(negedge clk);
    rst = 1'b0;
    no_response = 1'b0;
    busy_len = 2;
    wait_en(10, ok);
    checks++;
    if (!ok || c_wr_enable !== 1'b1 || c_wr_addr !== 24'h000ABC) begin
      errors++; $display("[TB] FAIL reset_regrant: wr_en=%b addr=%h, expected 1 000abc", c_wr_enable, c_wr_addr);
    end
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 2'b01 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_after_ack: ack=%b err=%b, expected 01 0", ack, err);
    end
    req[0] = 1'b0;
  endtask

  task automatic test_single_write();
    bit ok; bit stable; int pre; int n;
    do_reset();
    busy_len = 5;
    set_req(0, 1'b1, 24'h000123, 16'hBEEF);
    wait_en(10, ok);
    checks++;
    if (!ok || c_wr_enable !== 1'b1 || c_rd_enable !== 1'b0) begin
      errors++; $display("[TB] FAIL write_issue: wr_en=%b rd_en=%b, expected 1 0", c_wr_enable, c_rd_enable);
    end
    pre = 0; stable = 1'b1; n = 0;
    while (c_wr_enable === 1'b1 && n < 20) begin
      if (c_busy === 1'b0) pre++;
      if (c_wr_addr !== 24'h000123 || c_wr_data !== 16'hBEEF) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++;
    if (pre != 1) begin
      errors++; $display("[TB] FAIL write_pre_busy: enable cycles before busy=%0d, expected 1", pre);
    end
    checks++;
    if (!stable) begin
      errors++; $display("[TB] FAIL write_stable: addr/data changed during ISSUE, expected 000123/beef");
    end
    n = 0;
    while (c_busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (ack !== '0 || c_wr_enable !== 1'b0) begin
      errors++; $display("[TB] FAIL write_busy_fall: ack=%b wr_en=%b, expected 00 0", ack, c_wr_enable);
    end
    @(negedge clk);
    checks++;
    if (ack !== 2'b01 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL write_ack: ack=%b err=%b, expected 01 0", ack, err);
    end
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || c_wr_addr !== '0 || c_wr_data !== '0) begin
      errors++; $display("[TB] FAIL write_after_done: ack=%b addr=%h data=%h, expected 00 0 0", ack, c_wr_addr, c_wr_data);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    do_reset();
    busy_len = 3;
    rd_value = 16'h5A5A;
    set_req(1, 1'b0, 24'h000456, 16'h0000);
    wait_en(10, ok);
    checks++;
    if (!ok || c_rd_enable !== 1'b1 || c_wr_enable !== 1'b0 || c_wr_addr !== 24'h000456) begin
      errors++;
      $display("[TB] FAIL read_issue: rd_en=%b wr_en=%b addr=%h, expected 1 0 000456", c_rd_enable, c_wr_enable, c_wr_addr);
    end
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 2'b10 || rdata !== 16'h5A5A || err !== 1'b0) begin
      errors++; $display("[TB] FAIL read_ack: ack=%b rdata=%h err=%b, expected 10 5a5a 0", ack, rdata, err);
    end
    req[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok; int m_ptr; int w; int prev; logic [NREQ-1:0] exp_ack;
    do_reset();
    busy_len = 2;
    rd_value = 16'hC3C3;
    set_req(0, 1'b1, 24'h0A0A0A, 16'h1111);
    set_req(1, 1'b0, 24'h0B0B0B, 16'h0000);
    m_ptr = 0; prev = -1;
    for (int t = 0; t < 6; t++) begin
      wait_ack(40, ok);
      w = rr_model(2'b11, m_ptr);
      exp_ack = '0; exp_ack[w] = 1'b1;
      checks++;
      if (!ok || ack !== exp_ack || w == prev || (w == 1 && rdata !== 16'hC3C3)) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: ack=%b rdata=%h, expected %b (rdata c3c3 for requester 1)", t, ack, rdata, exp_ack);
      end
      prev = w;
      m_ptr = (w + 1) % NREQ;
    end
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_refresh();
    bit ok; bit bad;
    do_reset();
    refresh = 1'b1;
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 24'h00F00D, 16'h2222);
    bad = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (c_wr_enable !== 1'b0 || c_rd_enable !== 1'b0 || ack !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL refresh_hold: enable or ack seen while busy high, expected none");
    end
    refresh = 1'b0;
    busy_len = 2;
    wait_en(10, ok);
    checks++;
    if (!ok || c_wr_enable !== 1'b1 || c_wr_addr !== 24'h00F00D) begin
      errors++; $display("[TB] FAIL refresh_grant: wr_en=%b addr=%h, expected 1 00f00d", c_wr_enable, c_wr_addr);
    end
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 2'b01) begin
      errors++; $display("[TB] FAIL refresh_ack: ack=%b, expected 01", ack);
    end
    req[0] = 1'b0;
  endtask

`ifdef SDRAM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok; bit early; int hi;
    do_reset();
    no_response = 1'b1;
    set_req(0, 1'b1, 24'h000777, 16'h3333);
    set_req(1, 1'b0, 24'h000888, 16'h0000);
    wait_en(10, ok);
    hi = 0; early = 1'b0;
    while (c_wr_enable === 1'b1 && hi < 40) begin
      if (ack !== '0) early = 1'b1;
      hi++;
      @(negedge clk);
    end
    checks++;
    if (!ok || hi != ISSUE_MAX || early) begin
      errors++; $display("[TB] FAIL wd_issue_len: enable cycles=%0d, expected %0d with no early ack", hi, ISSUE_MAX);
    end
    checks++;
    if (ack !== 2'b01 || err !== 1'b1 || rdata !== '0) begin
      errors++; $display("[TB] FAIL wd_abort: ack=%b err=%b rdata=%h, expected 01 1 0", ack, err, rdata);
    end
    req[0] = 1'b0;
    no_response = 1'b0;
    busy_len = 2;
    rd_value = 16'h0F0F;
    @(negedge clk);
    checks++;
    if (c_wr_enable !== 1'b0 || c_rd_enable !== 1'b0 || ack !== '0 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_idle: wr_en=%b rd_en=%b ack=%b err=%b, expected all 0", c_wr_enable, c_rd_enable, ack, err);
    end
    @(negedge clk);
    checks++;
    if (c_rd_enable !== 1'b1 || c_wr_addr !== 24'h000888) begin
      errors++; $display("[TB] FAIL wd_next_grant: rd_en=%b addr=%h, expected 1 000888", c_rd_enable, c_wr_addr);
    end
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 2'b10 || err !== 1'b0 || rdata !== 16'h0F0F) begin
      errors++; $display("[TB] FAIL wd_next_ack: ack=%b err=%b rdata=%h, expected 10 0 0f0f", ack, err, rdata);
    end
    req[1] = 1'b0;
  endtask
`else
  task automatic test_stall();
    bit ok; bit bad;
    do_reset();
    no_response = 1'b1;
    set_req(0, 1'b1, 24'h000999, 16'h4444);
    wait_en(10, ok);
    bad = !ok;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (c_wr_enable !== 1'b1 || ack !== '0 || err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL stall_hold: wr_en=%b ack=%b err=%b, expected enable held, no ack/err", c_wr_enable, ack, err);
    end
    no_response = 1'b0;
    busy_len = 2;
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 2'b01 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_ack: ack=%b err=%b, expected 01 0", ack, err);
    end
    req[0] = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit in_flight; int cur; int age; int w; int m_ptr; bit ok;
    logic [DW-1:0] exp_rd; logic [NREQ-1:0] exp_ack;
    do_reset();
    in_flight = 1'b0; cur = 0; age = 0; m_ptr = 0; exp_rd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!in_flight) begin
        checks++;
        if (ack !== '0) begin
          errors++; $display("[TB] FAIL rand_spurious_ack: ack=%b at cycle %0d, expected 00", ack, cyc);
        end
        if (c_wr_enable === 1'b1 || c_rd_enable === 1'b1) begin
          w = rr_model(req_edge, m_ptr);
          checks++;
          if (w < 0) begin
            errors++; $display("[TB] FAIL rand_grant: enable with no request at cycle %0d, expected none", cyc);
            w = 0;
          end else if (c_wr_enable !== m_we[w] || c_rd_enable !== !m_we[w] || c_wr_addr !== m_addr[w] ||
                       (m_we[w] && c_wr_data !== m_data[w])) begin
            errors++;
            $display("[TB] FAIL rand_grant: wr_en=%b rd_en=%b addr=%h data=%h, expected requester %0d we=%b addr=%h data=%h",
                     c_wr_enable, c_rd_enable, c_wr_addr, c_wr_data, w, m_we[w], m_addr[w], m_data[w]);
          end
          in_flight = 1'b1; cur = w; age = 0; exp_rd = rd_value;
          m_ptr = (w + 1) % NREQ;
        end
      end else begin
        age++;
        if (ack !== '0) begin
          exp_ack = '0; exp_ack[cur] = 1'b1;
          checks++;
          if (ack !== exp_ack || err !== 1'b0 || (!m_we[cur] && rdata !== exp_rd)) begin
            errors++;
            $display("[TB] FAIL rand_ack: ack=%b err=%b rdata=%h, expected %b 0 rdata=%h (reads)", ack, err, rdata, exp_ack, exp_rd);
          end
          req[cur] = 1'b0;
          in_flight = 1'b0;
        end else if (age > 60) begin
          checks++; errors++;
          $display("[TB] FAIL rand_timeout: no ack within 60 cycles for requester %0d, expected ack", cur);
          break;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      if (!in_flight) begin
        busy_len = $urandom_range(1, 6);
        rd_value = DW'($urandom);
      end
    end
    if (in_flight) wait_ack(80, ok);
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_refresh();
`ifdef SDRAM_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_stall();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
